// File: rtl/unary_stream_decoder.sv
// Unary stream decoder: counts the ones in a STREAM_LEN-bit unary stream and
// reports running lower/upper bounds, a double-scale midpoint estimate and an
// early-convergence flag while the stream is in flight. The final count is
// held on a valid/ready result port until the binary back-end takes it.
module unary_stream_decoder #(
  parameter int STREAM_LEN  = 32,
  parameter int COUNT_WIDTH = $clog2(STREAM_LEN + 1),
  parameter int EPSILON     = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   bit_in,
  input  logic                   bit_valid,
  output logic [COUNT_WIDTH-1:0] lower_bound,
  output logic [COUNT_WIDTH-1:0] upper_bound,
  output logic [COUNT_WIDTH:0]   midpoint,
  output logic                   converged,
  output logic [COUNT_WIDTH-1:0] result,
  output logic                   result_valid,
  input  logic                   result_ready,
  output logic                   overrun
);

  typedef enum logic {COLLECT = 1'b0, HOLD = 1'b1} state_t;

  localparam logic [COUNT_WIDTH-1:0] LEN = COUNT_WIDTH'(STREAM_LEN);
  localparam logic [COUNT_WIDTH-1:0] ONE = COUNT_WIDTH'(1);

  state_t                 state, state_n;
  logic [COUNT_WIDTH-1:0] ones_cnt, ones_n;
  logic [COUNT_WIDTH-1:0] bit_cnt, bit_n;
  logic [COUNT_WIDTH-1:0] result_n;
  logic                   result_valid_n, overrun_n;

  logic [COUNT_WIDTH-1:0] base_bits, base_ones;
  logic [COUNT_WIDTH-1:0] bit_ext;
  logic [COUNT_WIDTH-1:0] remaining;
  logic                   take;
  logic                   handshake;

  assign bit_ext   = COUNT_WIDTH'(bit_in);
  assign handshake = result_valid && result_ready;

  // Derived status: bounds on the final count given what is still to come.
  always_comb begin
    remaining   = LEN - bit_cnt;
    lower_bound = ones_cnt;
    upper_bound = ones_cnt + remaining;
    midpoint    = {ones_cnt, 1'b0} + {1'b0, remaining};
    converged   = (state == COLLECT) && (int'(remaining) <= EPSILON);
  end

  // Next-state and datapath update. A handshake in HOLD restarts the counters
  // from zero and lets a same-cycle valid bit become bit 1 of the next stream,
  // so back-to-back streams lose no bit. With STREAM_LEN = 1 that bit can
  // complete the new stream immediately, which the shared accept path covers.
  always_comb begin
    state_n        = state;
    ones_n         = ones_cnt;
    bit_n          = bit_cnt;
    result_n       = result;
    result_valid_n = result_valid;
    overrun_n      = overrun;
    base_bits      = bit_cnt;
    base_ones      = ones_cnt;
    take           = 1'b0;
    if (clear) begin
      state_n        = COLLECT;
      ones_n         = '0;
      bit_n          = '0;
      result_valid_n = 1'b0;
      overrun_n      = 1'b0;
    end else begin
      unique case (state)
        COLLECT: take = bit_valid;
        HOLD: begin
          if (handshake) begin
            state_n        = COLLECT;
            result_valid_n = 1'b0;
            base_bits      = '0;
            base_ones      = '0;
            bit_n          = '0;
            ones_n         = '0;
            take           = bit_valid;
          end else if (bit_valid) begin
            overrun_n = 1'b1;
          end
        end
        default: state_n = COLLECT;
      endcase
      if (take) begin
        bit_n  = base_bits + ONE;
        ones_n = base_ones + bit_ext;
        if (bit_n == LEN) begin
          result_n       = ones_n;
          result_valid_n = 1'b1;
          state_n        = HOLD;
        end
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= COLLECT;
    else        state <= state_n;
  end

  // Counters, held result and sticky overrun flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ones_cnt     <= '0;
      bit_cnt      <= '0;
      result       <= '0;
      result_valid <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      ones_cnt     <= ones_n;
      bit_cnt      <= bit_n;
      result       <= result_n;
      result_valid <= result_valid_n;
      overrun      <= overrun_n;
    end
  end

endmodule

// File: tb/tb_unary_stream_decoder.sv
// Directed bench for unary_stream_decoder (STREAM_LEN = 8, EPSILON = 2).
// Inputs change 1 time unit after the rising edge; outputs are sampled there.
module tb_unary_stream_decoder;

  localparam int LEN = 8;
  localparam int CW  = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          clear = 1'b0;
  logic          bit_in = 1'b0;
  logic          bit_valid = 1'b0;
  logic          result_ready = 1'b0;
  logic [CW-1:0] lower_bound, upper_bound, result;
  logic [CW:0]   midpoint;
  logic          converged, result_valid, overrun;

  int checks = 0;
  int failures = 0;

  unary_stream_decoder #(.STREAM_LEN(LEN), .COUNT_WIDTH(CW), .EPSILON(2)) dut (
    .clk(clk), .reset(reset), .clear(clear), .bit_in(bit_in), .bit_valid(bit_valid),
    .lower_bound(lower_bound), .upper_bound(upper_bound), .midpoint(midpoint),
    .converged(converged), .result(result), .result_valid(result_valid),
    .result_ready(result_ready), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #3;
    checks++; if (lower_bound !== 4'd0) begin failures++; $display("FAIL reset_lower got=%0d exp=0", lower_bound); end
    checks++; if (upper_bound !== 4'd8) begin failures++; $display("FAIL reset_upper got=%0d exp=8", upper_bound); end
    checks++; if (midpoint !== 5'd8) begin failures++; $display("FAIL reset_mid got=%0d exp=8", midpoint); end
    checks++; if ({converged, result_valid, overrun} !== 3'b000) begin failures++; $display("FAIL reset_flags got=%b exp=000", {converged, result_valid, overrun}); end
    checks++; if (result !== 4'd0) begin failures++; $display("FAIL reset_result got=%0d exp=0", result); end
    tick();
    reset = 1'b1;
    tick();
  endtask

  // Pattern 1: continuous stream 1,0,1,1,0,0,1,1 with ready held high.
  task automatic test_stream_basic();
    logic [7:0] pat;
    pat = 8'hCD;
    result_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bit_valid = 1'b1; bit_in = pat[i];
      tick();
      if (i == 3) begin
        checks++; if (lower_bound !== 4'd3) begin failures++; $display("FAIL p1_lower4 got=%0d exp=3", lower_bound); end
        checks++; if (upper_bound !== 4'd7) begin failures++; $display("FAIL p1_upper4 got=%0d exp=7", upper_bound); end
        checks++; if (midpoint !== 5'd10) begin failures++; $display("FAIL p1_mid4 got=%0d exp=10", midpoint); end
        checks++; if (converged !== 1'b0) begin failures++; $display("FAIL p1_conv4 got=%b exp=0", converged); end
      end
      if (i == 5) begin
        checks++; if (converged !== 1'b1) begin failures++; $display("FAIL p1_conv6 got=%b exp=1", converged); end
      end
      if (i < 7) begin
        checks++; if (result_valid !== 1'b0) begin failures++; $display("FAIL p1_early_valid bit=%0d got=%b exp=0", i, result_valid); end
      end
    end
    checks++; if (result_valid !== 1'b1 || result !== 4'd5) begin failures++; $display("FAIL p1_result got=%b/%0d exp=1/5", result_valid, result); end
    bit_valid = 1'b0;
    tick();
    checks++; if (result_valid !== 1'b0) begin failures++; $display("FAIL p1_pulse got=%b exp=0", result_valid); end
    checks++; if (upper_bound !== 4'd8 || lower_bound !== 4'd0) begin failures++; $display("FAIL p1_restart got=%0d/%0d exp=0/8", lower_bound, upper_bound); end
  endtask

  // Pattern 2: gapped stream, result held while ready is low, overrun in HOLD.
  task automatic test_gaps_hold();
    logic [7:0] pat;
    pat = 8'hCD;
    result_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bit_valid = 1'b1; bit_in = pat[i];
      tick();
      bit_valid = 1'b0;
      tick();
    end
    checks++; if (result_valid !== 1'b1 || result !== 4'd5) begin failures++; $display("FAIL p2_result got=%b/%0d exp=1/5", result_valid, result); end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (result_valid !== 1'b1 || result !== 4'd5) begin failures++; $display("FAIL p2_hold cyc=%0d got=%b/%0d exp=1/5", i, result_valid, result); end
    end
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL p2_no_overrun got=%b exp=0", overrun); end
    bit_valid = 1'b1; bit_in = 1'b1;
    tick();
    checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL p2_overrun got=%b exp=1", overrun); end
    checks++; if (lower_bound !== 4'd5 || upper_bound !== 4'd5) begin failures++; $display("FAIL p2_counters got=%0d/%0d exp=5/5", lower_bound, upper_bound); end
    checks++; if (result_valid !== 1'b1 || result !== 4'd5) begin failures++; $display("FAIL p2_result_kept got=%b/%0d exp=1/5", result_valid, result); end
    bit_valid = 1'b0; result_ready = 1'b1;
    tick();
    checks++; if (result_valid !== 1'b0 || lower_bound !== 4'd0 || upper_bound !== 4'd8) begin
      failures++; $display("FAIL p2_handshake got=%b/%0d/%0d exp=0/0/8", result_valid, lower_bound, upper_bound); end
    checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL p2_sticky got=%b exp=1", overrun); end
    result_ready = 1'b0;
  endtask

  // Pattern 3: all ones, converged window with EPSILON = 2.
  task automatic test_converge();
    logic [7:0] expc;
    expc = 8'b0110_0000;  // converged after bits 6 and 7, low again in HOLD
    result_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bit_valid = 1'b1; bit_in = 1'b1;
      tick();
      checks++; if (converged !== expc[i]) begin failures++; $display("FAIL p3_conv bit=%0d got=%b exp=%b", i + 1, converged, expc[i]); end
    end
    checks++; if (result_valid !== 1'b1 || result !== 4'd8) begin failures++; $display("FAIL p3_result got=%b/%0d exp=1/8", result_valid, result); end
    bit_valid = 1'b0; result_ready = 1'b1;
    tick();
    checks++; if (result_valid !== 1'b0) begin failures++; $display("FAIL p3_handshake got=%b exp=0", result_valid); end
  endtask

  // Pattern 4: two streams back to back, no bubble at the handshake.
  task automatic test_back_to_back();
    result_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      bit_valid = 1'b1; bit_in = (i < 8);
      tick();
      if (i == 7) begin
        checks++; if (result_valid !== 1'b1 || result !== 4'd8) begin failures++; $display("FAIL p4_first got=%b/%0d exp=1/8", result_valid, result); end
      end
      if (i == 8) begin
        checks++; if (result_valid !== 1'b0 || lower_bound !== 4'd0 || upper_bound !== 4'd7) begin
          failures++; $display("FAIL p4_nobubble got=%b/%0d/%0d exp=0/0/7", result_valid, lower_bound, upper_bound); end
      end
    end
    checks++; if (result_valid !== 1'b1 || result !== 4'd0) begin failures++; $display("FAIL p4_second got=%b/%0d exp=1/0", result_valid, result); end
    bit_valid = 1'b0;
    tick();
    checks++; if (result_valid !== 1'b0) begin failures++; $display("FAIL p4_done got=%b exp=0", result_valid); end
  endtask

  // Pattern 5: clear mid-stream discards the partial count and overrun.
  task automatic test_clear();
    result_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bit_valid = 1'b1; bit_in = 1'b1;
      tick();
    end
    checks++; if (lower_bound !== 4'd3) begin failures++; $display("FAIL p5_pre got=%0d exp=3", lower_bound); end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    checks++; if (lower_bound !== 4'd0 || upper_bound !== 4'd8) begin failures++; $display("FAIL p5_clear got=%0d/%0d exp=0/8", lower_bound, upper_bound); end
    checks++; if (overrun !== 1'b0 || result_valid !== 1'b0) begin failures++; $display("FAIL p5_flags got=%b/%b exp=0/0", overrun, result_valid); end
    for (int i = 0; i < 8; i++) begin
      bit_valid = 1'b1; bit_in = 1'b0;
      tick();
      if (i == 6) begin
        checks++; if (upper_bound !== 4'd1 || result_valid !== 1'b0) begin failures++; $display("FAIL p5_seven got=%0d/%b exp=1/0", upper_bound, result_valid); end
      end
    end
    checks++; if (result_valid !== 1'b1 || result !== 4'd0) begin failures++; $display("FAIL p5_result got=%b/%0d exp=1/0", result_valid, result); end
    bit_valid = 1'b0; result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
  endtask

  // Pattern 6: asynchronous reset in HOLD and mid-stream, then a clean stream.
  task automatic test_async_reset();
    logic [7:0] pat;
    for (int i = 0; i < 8; i++) begin
      bit_valid = 1'b1; bit_in = 1'b1;
      tick();
    end
    bit_in = 1'b1;
    tick();  // dropped bit in HOLD sets overrun
    bit_valid = 1'b0;
    checks++; if (result_valid !== 1'b1 || result !== 4'd8 || overrun !== 1'b1) begin
      failures++; $display("FAIL p6_setup got=%b/%0d/%b exp=1/8/1", result_valid, result, overrun); end
    #2 reset = 1'b0;
    #1;
    checks++; if (result_valid !== 1'b0 || result !== 4'd0 || overrun !== 1'b0) begin
      failures++; $display("FAIL p6_async_hold got=%b/%0d/%b exp=0/0/0", result_valid, result, overrun); end
    #1 reset = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      bit_valid = 1'b1; bit_in = 1'b1;
      tick();
    end
    bit_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    checks++; if (lower_bound !== 4'd0 || upper_bound !== 4'd8 || midpoint !== 5'd8) begin
      failures++; $display("FAIL p6_async_mid got=%0d/%0d/%0d exp=0/8/8", lower_bound, upper_bound, midpoint); end
    #1 reset = 1'b1;
    tick();
    pat = 8'hA5;
    for (int i = 0; i < 8; i++) begin
      bit_valid = 1'b1; bit_in = pat[i];
      tick();
    end
    bit_valid = 1'b0;
    checks++; if (result_valid !== 1'b1 || result !== 4'd4) begin failures++; $display("FAIL p6_result got=%b/%0d exp=1/4", result_valid, result); end
  endtask

  initial begin
    test_reset();
    test_stream_basic();
    test_gaps_hold();
    test_converge();
    test_back_to_back();
    test_clear();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/unary_stream_decoder.md
Name: unary_stream_decoder

Overview:
- Downstream consumer of the unary adder's serial output (`y`/`valid`).
- Counts the ones in a STREAM_LEN-bit unary stream and reports running lower/upper bounds while the stream is in flight.
- Flags early convergence when the remaining bits cannot move the result by more than EPSILON.
- Presents the final binary count on a valid/ready result port for the binary back-end.

Parameters:
- STREAM_LEN, 32, number of bits in one unary stream; must be ≥ 1.
- COUNT_WIDTH, $clog2(STREAM_LEN+1), width of the ones/bit counters.
- EPSILON, 0, convergence tolerance in ones.

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-low reset.
- clear  input  1  synchronous abort; restarts collection.
- bit_in  input  1  unary data bit (adder `y`).
- bit_valid  input  1  bit_in qualifier (adder `valid`).
- lower_bound  output  COUNT_WIDTH  ones seen so far.
- upper_bound  output  COUNT_WIDTH  ones seen + bits remaining.
- midpoint  output  COUNT_WIDTH+1  2*ones + remaining (double-scale estimate).
- converged  output  1  remaining ≤ EPSILON while collecting.
- result  output  COUNT_WIDTH  final ones count.
- result_valid  output  1  result held for consumer.
- result_ready  input  1  consumer accepts result.
- overrun  output  1  sticky: a valid bit arrived while no stream was being collected.

Behaviour:
- Reset values (asynchronous, reset low):
  - state = COLLECT; ones_cnt = 0, bit_cnt = 0.
  - result = 0, result_valid = 0, overrun = 0.
  - Derived outputs at reset: lower_bound = 0, upper_bound = STREAM_LEN, midpoint = STREAM_LEN, converged = (STREAM_LEN ≤ EPSILON).
- Derived, combinational from registers:
  - remaining = STREAM_LEN − bit_cnt.
  - lower_bound = ones_cnt.
  - upper_bound = ones_cnt + remaining.
  - midpoint = (ones_cnt<<1) + remaining, computed at COUNT_WIDTH+1 bits with no truncation.
  - converged = (state == COLLECT) && (remaining ≤ EPSILON).
- State COLLECT, on a cycle with bit_valid = 1:
  - bit_cnt += 1 and ones_cnt += bit_in.
  - If the increment makes bit_cnt == STREAM_LEN:
    - result ← ones_cnt + bit_in;
    - result_valid ← 1;
    - state ← HOLD.
  - Latency: result_valid is high in the cycle after the final valid bit is sampled.
- State COLLECT, bit_valid = 0: hold all registers.
- State HOLD:
  - result and result_valid are held stable until result_valid && result_ready.
  - On the handshake: result_valid ← 0, counters ← 0, state ← COLLECT.
  - If bit_valid = 1 in the handshake cycle, that bit is the first bit of the next stream: bit_cnt ← 1, ones_cnt ← bit_in. No bubble.
  - bit_valid = 1 in HOLD without a handshake: the bit is dropped and overrun ← 1. Counters are unchanged.
- STREAM_LEN = 1: every accepted bit completes a stream immediately (COLLECT → HOLD on each valid bit).
- clear = 1 (highest synchronous priority):
  - counters ← 0, result_valid ← 0, overrun ← 0, state ← COLLECT.
  - bit_valid in the same cycle is ignored.
  - result is not cleared (stale value, not valid).
- Reset asserted mid-stream: immediate return to the reset values; the partial stream is discarded.
- Counters never exceed STREAM_LEN; no wrap is possible because COLLECT leaves at STREAM_LEN.
- converged is informational only. It never truncates the stream or asserts result_valid early.

Test Plan:
- Pattern 1: STREAM_LEN = 8, bits 1,0,1,1,0,0,1,1 with bit_valid = 1 every cycle, result_ready = 1 → result_valid high in the cycle after the 8th bit, result = 5, one-cycle pulse. During the stream after 4 bits: lower_bound = 3, upper_bound = 7, midpoint = 10.
- Pattern 2: same stream with gaps (bit_valid toggling 1/0), result_ready = 0 for 5 cycles after completion → result = 5 held stable with result_valid = 1. Then:
  - a valid bit during the hold sets overrun = 1 and does not alter the counters;
  - asserting result_ready then completes the handshake.
- Pattern 3: EPSILON = 2, STREAM_LEN = 8, all-ones input → converged rises after the 6th bit (remaining = 2) and falls on entry to HOLD; result = 8.
- Pattern 4: back-to-back streams, result_ready = 1, bit_valid held high for 16 cycles, first stream all ones, second all zeros → results 8 then 0, no lost bit (first bit of stream 2 accepted in the handshake cycle).
- Pattern 5: assert clear after 3 bits (each bit = 1) → lower_bound = 0, upper_bound = 8 next cycle, overrun = 0. The following 8 valid zero bits yield result = 0.
- Pattern 6: drop reset low asynchronously mid-stream → outputs go to reset values immediately without waiting for clk. After release, a full 8-bit stream of four ones decodes to result = 4.
